// File: rtl/genius_pkg.sv
// Shared definitions for the Genius button decoder: button indices and codes,
// decoder FSM encoding and LFSR constants.
package genius_pkg;

  localparam int NUM_BTN = 5;

  localparam int IDX_POWER  = 0;
  localparam int IDX_GREEN  = 1;
  localparam int IDX_RED    = 2;
  localparam int IDX_BLUE   = 3;
  localparam int IDX_YELLOW = 4;

  typedef enum logic [2:0] {
    CODE_NONE   = 3'd0,
    CODE_POWER  = 3'd1,
    CODE_GREEN  = 3'd2,
    CODE_RED    = 3'd3,
    CODE_BLUE   = 3'd4,
    CODE_YELLOW = 3'd6
  } btn_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCEPT  = 2'd1,
    ST_HELD    = 2'd2,
    ST_LOCKOUT = 2'd3
  } dec_state_e;

  localparam int          LFSR_W    = 16;
  // Taps at bits 15, 13, 12, 10 (x^16 + x^14 + x^13 + x^11 + 1).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic btn_code_e code_of(input logic [2:0] idx);
    case (int'(idx))
      IDX_POWER:  code_of = CODE_POWER;
      IDX_GREEN:  code_of = CODE_GREEN;
      IDX_RED:    code_of = CODE_RED;
      IDX_BLUE:   code_of = CODE_BLUE;
      IDX_YELLOW: code_of = CODE_YELLOW;
      default:    code_of = CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/genius_button_decoder_if.sv
// Button/colour bus between the raw-button front end and the Genius controller.
interface genius_button_decoder_if;
  import genius_pkg::*;

  logic [NUM_BTN-1:0] BTN_RAW;
  logic               R;
  logic [2:0]         B;
  logic [1:0]         C;
  logic               BTN_HELD;

  modport master (output BTN_RAW, input R, B, C, BTN_HELD);
  modport slave  (input BTN_RAW, output R, B, C, BTN_HELD);
endinterface

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser, sample register and a mismatch counter that
// flips the stable level after DEBOUNCE_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, sample_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable gets its default before any branch, so no path leaves
  // it unassigned and no latch is inferred; blocking '=' is correct in comb logic.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sample_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sample_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: reset is synchronous and active-high, so RESET is tested inside the
  // clocked block rather than appearing in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sample_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      sample_q <= sync2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/genius_button_decoder.sv
// Genius front end: debounces five buttons, accepts one clean press at a time
// (R pulse + held code on B) and supplies a pseudo-random colour from an LFSR.
module genius_button_decoder
  import genius_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  genius_button_decoder_if.slave  bus
);

  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [NUM_BTN-1:0] stable;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .CLK     (CLK),
      .RESET   (RESET),
      .btn_i   (bus.BTN_RAW[i]),
      .level_o (stable[i])
    );
  end

  dec_state_e  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  logic [2:0]         hot_cnt;
  logic [2:0]         hot_idx;
  logic [NUM_BTN-1:0] others;

  always_comb begin
    hot_cnt = '0;
    hot_idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (stable[i]) begin
        hot_cnt = hot_cnt + 3'd1;
        hot_idx = 3'(i);
      end
    end
    others = stable & ~(NUM_BTN'(1) << idx_q);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (hot_cnt == 3'd1) begin
          state_d = ST_ACCEPT;
          idx_d   = hot_idx;
        end else if (hot_cnt > 3'd1) begin
          state_d = ST_LOCKOUT;
        end
      end
      ST_ACCEPT: state_d = ST_HELD;
      ST_HELD: begin
        // Presses of other buttons are ignored until the latched one releases.
        if (!stable[idx_q]) begin
          state_d = (|others) ? ST_LOCKOUT : ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (stable == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      lfsr_q  <= SEED_EFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
    end
  end

  logic active;
  assign active       = (state_q == ST_ACCEPT) || (state_q == ST_HELD);
  assign bus.R        = (state_q == ST_ACCEPT);
  assign bus.BTN_HELD = active;
  assign bus.B        = active ? code_of(idx_q) : CODE_NONE;
  assign bus.C        = lfsr_q[1:0];

endmodule

// File: tb/tb_genius_button_decoder.sv
// Directed bench for genius_button_decoder with DEBOUNCE_CYCLES=4: a segment
// table for press/release scenarios plus timed sequences and an LFSR sweep.
module tb_genius_button_decoder;

  localparam int          DEB  = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam logic [4:0] B_POWER  = 5'b00001;
  localparam logic [4:0] B_GREEN  = 5'b00010;
  localparam logic [4:0] B_RED    = 5'b00100;
  localparam logic [4:0] B_BLUE   = 5'b01000;
  localparam logic [4:0] B_YELLOW = 5'b10000;

  logic CLK = 1'b0;
  logic RESET;

  genius_button_decoder_if bus_if ();

  genius_button_decoder #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (16),
    .LFSR_SEED       (SEED)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return {l[14:0], fb};
  endfunction

  typedef struct {
    string      name;
    logic [4:0] raw;
    int         cycles;
    int         exp_r;
    logic [2:0] exp_b;
    logic       exp_held;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int          rcnt;
    logic [15:0] model;

    vecs[0] = '{"glitch_red",     B_RED,            3,  0, 3'd0, 1'b0};
    vecs[1] = '{"glitch_idle",    5'b0,             12, 0, 3'd0, 1'b0};
    vecs[2] = '{"bluyel_press",   B_BLUE | B_YELLOW, 12, 0, 3'd0, 1'b0};
    vecs[3] = '{"bluyel_release", 5'b0,             10, 0, 3'd0, 1'b0};
    vecs[4] = '{"power_press",    B_POWER,          10, 1, 3'd1, 1'b1};
    vecs[5] = '{"power_release",  5'b0,             10, 0, 3'd0, 1'b0};
    vecs[6] = '{"red_press",      B_RED,            10, 1, 3'd3, 1'b1};
    vecs[7] = '{"red_green",      B_RED | B_GREEN,  10, 0, 3'd3, 1'b1};
    vecs[8] = '{"green_only",     B_GREEN,          10, 0, 3'd0, 1'b0};
    vecs[9] = '{"green_release",  5'b0,             10, 0, 3'd0, 1'b0};

    // Reset state.
    RESET          = 1'b1;
    bus_if.BTN_RAW = '0;
    step();
    step();
    check("rst_r",    32'(bus_if.R),        32'd0);
    check("rst_b",    32'(bus_if.B),        32'd0);
    check("rst_held", 32'(bus_if.BTN_HELD), 32'd0);
    check("rst_c",    32'(bus_if.C),        32'(SEED[1:0]));
    RESET = 1'b0;
    step();

    // Clean GREEN press: raw set before edge 0, released before edge 20.
    bus_if.BTN_RAW = B_GREEN;
    for (int n = 0; n <= 30; n++) begin
      if (n == 20) bus_if.BTN_RAW = '0;
      step();
      check($sformatf("green_r_e%0d", n), 32'(bus_if.R), (n == 7) ? 32'd1 : 32'd0);
      check($sformatf("green_b_e%0d", n), 32'(bus_if.B), (n >= 7 && n <= 26) ? 32'd2 : 32'd0);
    end

    // Segment table: apply raw level, count R pulses, check final B/BTN_HELD.
    for (int v = 0; v < 10; v++) begin
      bus_if.BTN_RAW = vecs[v].raw;
      rcnt = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step();
        if (bus_if.R === 1'b1) rcnt++;
      end
      check({vecs[v].name, ".r_count"}, 32'(rcnt),            32'(vecs[v].exp_r));
      check({vecs[v].name, ".b"},       32'(bus_if.B),        32'(vecs[v].exp_b));
      check({vecs[v].name, ".held"},    32'(bus_if.BTN_HELD), 32'(vecs[v].exp_held));
    end

    // Reset while YELLOW is held, then re-acceptance of the same press.
    bus_if.BTN_RAW = B_YELLOW;
    for (int c = 0; c < 10; c++) step();
    check("yel_pre_b",    32'(bus_if.B),        32'd6);
    check("yel_pre_held", 32'(bus_if.BTN_HELD), 32'd1);
    RESET = 1'b1;
    step();
    check("midrst_r",    32'(bus_if.R),        32'd0);
    check("midrst_b",    32'(bus_if.B),        32'd0);
    check("midrst_held", 32'(bus_if.BTN_HELD), 32'd0);
    RESET = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      step();
      check($sformatf("yel_r_e%0d", n), 32'(bus_if.R), (n == 7) ? 32'd1 : 32'd0);
      if (n == 7) check("yel_b_at_r", 32'(bus_if.B), 32'd6);
    end
    bus_if.BTN_RAW = '0;
    for (int c = 0; c < 10; c++) step();
    check("yel_rel_b", 32'(bus_if.B), 32'd0);

    // LFSR sweep over one full period from reset.
    RESET = 1'b1;
    step();
    model = SEED;
    check("lfsr_seed", 32'(dut.lfsr_q), 32'(model));
    RESET = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      step();
      model = lfsr_next(model);
      check($sformatf("lfsr_c_%0d", i),    32'(bus_if.C),      32'(model[1:0]));
      check($sformatf("lfsr_q_%0d", i),    32'(dut.lfsr_q),    32'(model));
      check($sformatf("lfsr_nz_%0d", i),   32'(dut.lfsr_q == 16'h0), 32'd0);
    end
    check("lfsr_period", 32'(dut.lfsr_q), 32'(SEED));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
